multicycle_maindec: RTL and testbench
=====================================

# multicycle_maindec

Multicycle successor of the single-cycle LEGv8 main decoder. A state machine sequences FETCH/DECODE/EXEC/MEM/WB, issuing the familiar control signals (Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) only in the cycles where they apply. It adds the following over the single-cycle decoder:
- stall handshakes with instruction and data memory;
- optional ADDI/SUBI decoding;
- memory-timeout and invalid-opcode exceptions;
- a retired-instruction counter.

It sits between the instruction register and the multicycle datapath, next to the ALU decoder.

## Interface
- OP_W, 11, opcode width; opcode matching uses Op[OP_W-1:OP_W-11].
- EN_IMM, 1, when 1, ADDI/SUBI are legal; when 0 they are invalid opcodes.
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for mem_ready (≥1).
- CNT_W, 32, width of the retired-instruction counter.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Op  in  OP_W  opcode from the instruction register.
- instr_valid  in  1  instruction memory has a valid word for the current PC.
- mem_ready  in  1  data memory access completes this cycle.
- exc_clear  in  1  leave the EXC state.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- ALUOp  out  2  to the ALU decoder.
- IRWrite, PCWrite  out  1 each  load instruction register / PC+4.
- Exc  out  1  exception state active.
- ExcCause  out  2  01 invalid opcode, 10 memory timeout, 00 none.
- state  out  3  debug encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation

**Opcode classes** (top 11 bits of Op):
- LDUR: 11111000010
- STUR: 11111000000
- CBZ: 10110100xxx
- ADD: 10001011000
- SUB: 11001011000
- AND: 10001010000
- ORR: 10101010000
- ADDI: 1001000100x (only if EN_IMM)
- SUBI: 1101000100x (only if EN_IMM)
- Anything else is invalid.

**Class control values.** Asserted in EXEC, MEM and WB only; 0 in FETCH, DECODE and EXC.
- LDUR: ALUSrc=1, MemtoReg=1, ALUOp=00.
- STUR: Reg2Loc=1, ALUSrc=1, ALUOp=00.
- CBZ: Reg2Loc=1, ALUOp=01.
- R-type: ALUOp=10.
- ADDI/SUBI: ALUSrc=1, ALUOp=10.

**Strobes.** Never asserted outside the states listed.
- IRWrite, PCWrite: FETCH, only when instr_valid=1.
- Branch: EXEC, CBZ only.
- MemRead: MEM, LDUR only.
- MemWrite: MEM, STUR only.
- RegWrite: WB only.

**Transitions.**
- FETCH: instr_valid=0 → stay. instr_valid=1 → DECODE.
- DECODE: class captured into an internal register. Invalid → EXC with ExcCause=01. Otherwise → EXEC.
- EXEC: LDUR/STUR → MEM. CBZ → FETCH (retire). R-type/ADDI/SUBI → WB.
- MEM:
  - Wait counter is cleared on entry.
  - mem_ready=1: LDUR → WB; STUR → FETCH (retire).
  - mem_ready=0 and counter==MEM_TIMEOUT-1 → EXC with ExcCause=10.
  - Otherwise the counter increments and the state stays MEM.
  - mem_ready=1 wins over timeout in the same cycle.
- WB → FETCH (retire).
- EXC: Exc=1, ExcCause held. exc_clear=1 → FETCH, with ExcCause cleared to 00 on that transition. Exceptions do not retire.

**Other rules.**
- Retire: instr_count increments by 1 on the clock edge leaving the retiring state; it wraps from all-ones to 0.
- Op is sampled only in DECODE. Op changes in later states have no effect on outputs.
- exc_clear outside EXC is ignored. mem_ready outside MEM is ignored. instr_valid outside FETCH is ignored.

## Timing
- Reset (reset=0 at a rising edge): state=FETCH, ExcCause=00, instr_count=0, wait counter=0. All control outputs then reflect FETCH: 0, except IRWrite/PCWrite, which follow instr_valid.
- Reset mid-operation aborts the instruction. No RegWrite, MemWrite or retire occurs on the cycle after the reset edge.
- All outputs are decoded from registered state and class (Moore), except IRWrite/PCWrite, which are combinational with instr_valid in FETCH.
- Latency with instr_valid and mem_ready already high, FETCH to FETCH:
  - CBZ: 3 cycles.
  - R-type/ADDI/SUBI: 4 cycles.
  - STUR: 4 cycles + k memory wait cycles.
  - LDUR: 5 cycles + k memory wait cycles.
- Timeout: at most MEM_TIMEOUT cycles in MEM. EXC is entered on the edge ending the MEM_TIMEOUT-th cycle.

## Test plan
- Reset, then ADD (10001011000) with instr_valid=1 → states 0,1,2,4,0. RegWrite=1 only in WB, ALUOp=10 in EXEC/WB, instr_count=1.
- LDUR with mem_ready low for 3 MEM cycles → MemRead=1 for 4 cycles, MemtoReg=1 and ALUSrc=1 in EXEC/MEM/WB, RegWrite for 1 cycle, 8 cycles total, instr_count +1.
- STUR with mem_ready never high, MEM_TIMEOUT=16 → exactly 16 MEM cycles with MemWrite=1, then Exc=1, ExcCause=10, no retire. exc_clear → FETCH, ExcCause=00.
- CBZ (10110100101) → Branch=1 and Reg2Loc=1 only in EXEC, ALUOp=01, 3-cycle instruction. Opcode 00000000000 → EXC with ExcCause=01 after DECODE.
- EN_IMM=1 ADDI (10010001000) → ALUSrc=1, ALUOp=10, RegWrite in WB. With EN_IMM=0, the same opcode → ExcCause=01.
- reset=0 asserted during LDUR's MEM state → next cycle state=FETCH, MemRead=0, RegWrite=0, instr_count=0. CNT_W=4: 16 CBZs → instr_count wraps from 15 to 0.

Source files
------------

// File: rtl/multicycle_maindec.sv
// multicycle_maindec: multicycle LEGv8 main decoder FSM with memory stalls, exceptions and a retire counter
module multicycle_maindec #(
    parameter int OP_W        = 11,
    parameter int EN_IMM      = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  Op,
    input  logic             instr_valid,
    input  logic             mem_ready,
    input  logic             exc_clear,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Exc,
    output logic [1:0]       ExcCause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, EXC = 3'd5} state_t;
    typedef enum logic [2:0] {C_LDUR, C_STUR, C_CBZ, C_R, C_IMM, C_INV} cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls;
    logic [1:0]       cause_q, cause_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      op11;
    logic             retire, act;
    logic             unused_op;

    assign op11      = Op[OP_W-1 -: 11];
    assign unused_op = ^Op;

    // classify the opcode presented by the instruction register
    always_comb begin
        dec_cls = C_INV;
        casez (op11)
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b10110100???: dec_cls = C_CBZ;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = C_R;
            11'b1001000100?,
            11'b1101000100?: dec_cls = EN_IMM != 0 ? C_IMM : C_INV;
            default:         dec_cls = C_INV;
        endcase
    end

    // next state, captured class, exception cause, memory wait counter and retire
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cause_d = cause_q;
        wait_d  = '0;
        retire  = 1'b0;
        case (state_q)
            FETCH:  state_d = instr_valid ? DECODE : FETCH;
            DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_cls == C_INV ? EXC : EXEC;
                cause_d = dec_cls == C_INV ? 2'b01 : cause_q;
            end
            EXEC: begin
                state_d = (cls_q == C_LDUR || cls_q == C_STUR) ? MEM : cls_q == C_CBZ ? FETCH : WB;
                retire  = cls_q == C_CBZ;
            end
            MEM: begin
                if (mem_ready) begin
                    state_d = cls_q == C_LDUR ? WB : FETCH;
                    retire  = cls_q != C_LDUR;
                end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                    state_d = EXC;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            EXC: begin
                state_d = exc_clear ? FETCH : EXC;
                cause_d = exc_clear ? 2'b00 : cause_q;
            end
            default: state_d = FETCH;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            cls_q   <= C_INV;
            cause_q <= 2'b00;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign act = state_q == EXEC || state_q == MEM || state_q == WB;

    // Moore control decode; only IRWrite/PCWrite look at a live input
    always_comb begin
        Reg2Loc  = act && (cls_q == C_STUR || cls_q == C_CBZ);
        ALUSrc   = act && (cls_q == C_LDUR || cls_q == C_STUR || cls_q == C_IMM);
        MemtoReg = act && cls_q == C_LDUR;
        ALUOp    = !act ? 2'b00 : cls_q == C_CBZ ? 2'b01 : (cls_q == C_R || cls_q == C_IMM) ? 2'b10 : 2'b00;
        Branch   = state_q == EXEC && cls_q == C_CBZ;
        MemRead  = state_q == MEM && cls_q == C_LDUR;
        MemWrite = state_q == MEM && cls_q == C_STUR;
        RegWrite = state_q == WB;
        IRWrite  = state_q == FETCH && instr_valid;
        PCWrite  = state_q == FETCH && instr_valid;
        Exc      = state_q == EXC;
    end

    assign ExcCause    = cause_q;
    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_maindec.sv
// tb_multicycle_maindec: directed self-checking bench for multicycle_maindec
module tb_multicycle_maindec;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] Op = '0;
    logic        instr_valid = 1'b0, mem_ready = 1'b0, exc_clear = 1'b0;

    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite, Exc;
    logic [1:0]  ALUOp, ExcCause;
    logic [2:0]  state;
    logic [31:0] instr_count;

    logic        z_r2l, z_src, z_m2r, z_rw, z_mr, z_mw, z_br, z_ir, z_pc, z_exc;
    logic [1:0]  z_aop, z_cause;
    logic [2:0]  z_state;
    logic [31:0] z_count;

    logic        w_r2l, w_src, w_m2r, w_rw, w_mr, w_mw, w_br, w_ir, w_pc, w_exc;
    logic [1:0]  w_aop, w_cause;
    logic [2:0]  w_state;
    logic [3:0]  w_count;

    int n_cmp = 0;
    int n_err = 0;
    int mem_cycles;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;

    always #5 clk = ~clk;

    multicycle_maindec #(.OP_W(11), .EN_IMM(1), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Op(Op), .instr_valid(instr_valid), .mem_ready(mem_ready), .exc_clear(exc_clear),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Exc(Exc), .ExcCause(ExcCause), .state(state), .instr_count(instr_count));

    multicycle_maindec #(.OP_W(11), .EN_IMM(0), .MEM_TIMEOUT(16), .CNT_W(32)) dut_noimm (
        .clk(clk), .reset(reset), .Op(Op), .instr_valid(instr_valid), .mem_ready(mem_ready), .exc_clear(exc_clear),
        .Reg2Loc(z_r2l), .ALUSrc(z_src), .MemtoReg(z_m2r), .RegWrite(z_rw), .MemRead(z_mr),
        .MemWrite(z_mw), .Branch(z_br), .ALUOp(z_aop), .IRWrite(z_ir), .PCWrite(z_pc),
        .Exc(z_exc), .ExcCause(z_cause), .state(z_state), .instr_count(z_count));

    multicycle_maindec #(.OP_W(11), .EN_IMM(1), .MEM_TIMEOUT(16), .CNT_W(4)) dut_wrap (
        .clk(clk), .reset(reset), .Op(Op), .instr_valid(instr_valid), .mem_ready(mem_ready), .exc_clear(exc_clear),
        .Reg2Loc(w_r2l), .ALUSrc(w_src), .MemtoReg(w_m2r), .RegWrite(w_rw), .MemRead(w_mr),
        .MemWrite(w_mw), .Branch(w_br), .ALUOp(w_aop), .IRWrite(w_ir), .PCWrite(w_pc),
        .Exc(w_exc), .ExcCause(w_cause), .state(w_state), .instr_count(w_count));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        exc_clear = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_cause", ExcCause, 0);
        chk("rst_exc", Exc, 0);
        chk("rst_irwrite_idle", IRWrite, 0);
        chk("rst_wrap_count", w_count, 0);
        chk("fetch_idle_stay_state", state, 0);
        Op = OP_ADD;
        instr_valid = 1'b1;
        #1;
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_pcwrite", PCWrite, 1);
        chk("fetch_aluop", ALUOp, 0);
        cyc();
        chk("add_decode_state", state, 1);
        chk("add_decode_irwrite", IRWrite, 0);
        chk("add_decode_aluop", ALUOp, 0);
        cyc();
        chk("add_exec_state", state, 2);
        chk("add_exec_aluop", ALUOp, 2);
        chk("add_exec_regwrite", RegWrite, 0);
        cyc();
        chk("add_wb_state", state, 4);
        chk("add_wb_regwrite", RegWrite, 1);
        chk("add_wb_aluop", ALUOp, 2);
        chk("add_wb_alusrc", ALUSrc, 0);
        cyc();
        chk("add_done_state", state, 0);
        chk("add_done_count", instr_count, 1);
        chk("add_done_regwrite", RegWrite, 0);

        Op = OP_LDUR;
        mem_ready = 1'b0;
        cyc();
        chk("ld_decode_state", state, 1);
        instr_valid = 1'b0;
        cyc();
        chk("ld_exec_state", state, 2);
        chk("ld_exec_alusrc", ALUSrc, 1);
        chk("ld_exec_memtoreg", MemtoReg, 1);
        chk("ld_exec_memread", MemRead, 0);
        chk("ld_exec_aluop", ALUOp, 0);
        Op = 11'b00000000000;
        mem_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (state == 3'd3 && MemRead) mem_cycles++;
            if (i == 3) begin
                chk("ld_mem_memtoreg", MemtoReg, 1);
                chk("ld_mem_alusrc", ALUSrc, 1);
                mem_ready = 1'b1;
            end
        end
        chk("ld_memread_cycles", mem_cycles, 4);
        cyc();
        mem_ready = 1'b0;
        chk("ld_wb_state", state, 4);
        chk("ld_wb_regwrite", RegWrite, 1);
        chk("ld_wb_memtoreg", MemtoReg, 1);
        chk("ld_wb_memread", MemRead, 0);
        cyc();
        chk("ld_done_state", state, 0);
        chk("ld_done_count", instr_count, 2);

        do_reset();
        Op = OP_STUR;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        cyc();
        chk("st_exec_state", state, 2);
        chk("st_exec_reg2loc", Reg2Loc, 1);
        chk("st_exec_alusrc", ALUSrc, 1);
        chk("st_exec_memwrite", MemWrite, 0);
        exc_clear = 1'b1;
        cyc();
        exc_clear = 1'b0;
        mem_cycles = 0;
        if (state == 3'd3 && MemWrite) mem_cycles++;
        for (int i = 1; i < 16; i++) begin
            cyc();
            if (state == 3'd3 && MemWrite) mem_cycles++;
        end
        chk("st_memwrite_cycles", mem_cycles, 16);
        cyc();
        chk("st_to_state", state, 5);
        chk("st_to_exc", Exc, 1);
        chk("st_to_cause", ExcCause, 2);
        chk("st_to_memwrite", MemWrite, 0);
        chk("st_to_count", instr_count, 0);
        cyc();
        chk("st_exc_hold_state", state, 5);
        chk("st_exc_hold_cause", ExcCause, 2);
        exc_clear = 1'b1;
        cyc();
        exc_clear = 1'b0;
        chk("st_clear_state", state, 0);
        chk("st_clear_cause", ExcCause, 0);
        chk("st_clear_exc", Exc, 0);
        chk("st_clear_count", instr_count, 0);

        Op = OP_CBZ;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("cbz_decode_branch", Branch, 0);
        chk("cbz_decode_reg2loc", Reg2Loc, 0);
        cyc();
        chk("cbz_exec_state", state, 2);
        chk("cbz_exec_branch", Branch, 1);
        chk("cbz_exec_reg2loc", Reg2Loc, 1);
        chk("cbz_exec_aluop", ALUOp, 1);
        cyc();
        chk("cbz_done_state", state, 0);
        chk("cbz_done_branch", Branch, 0);
        chk("cbz_done_count", instr_count, 1);

        Op = 11'b00000000000;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("inv_decode_state", state, 1);
        cyc();
        chk("inv_state", state, 5);
        chk("inv_cause", ExcCause, 1);
        chk("inv_exc", Exc, 1);
        chk("inv_regwrite", RegWrite, 0);
        exc_clear = 1'b1;
        cyc();
        exc_clear = 1'b0;
        chk("inv_clear_state", state, 0);
        chk("inv_clear_cause", ExcCause, 0);
        chk("inv_count", instr_count, 1);

        do_reset();
        Op = OP_ADDI;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        cyc();
        chk("addi_exec_state", state, 2);
        chk("addi_exec_alusrc", ALUSrc, 1);
        chk("addi_exec_aluop", ALUOp, 2);
        chk("addi_noimm_state", z_state, 5);
        chk("addi_noimm_cause", z_cause, 1);
        cyc();
        chk("addi_wb_regwrite", RegWrite, 1);
        chk("addi_wb_alusrc", ALUSrc, 1);
        cyc();
        chk("addi_done_count", instr_count, 1);

        do_reset();
        Op = OP_LDUR;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        cyc();
        cyc();
        chk("rstmid_mem_state", state, 3);
        chk("rstmid_mem_memread", MemRead, 1);
        mem_ready = 1'b1;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        mem_ready = 1'b0;
        chk("rstmid_state", state, 0);
        chk("rstmid_memread", MemRead, 0);
        chk("rstmid_regwrite", RegWrite, 0);
        chk("rstmid_count", instr_count, 0);

        do_reset();
        Op = OP_CBZ;
        instr_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cyc();
            cyc();
            cyc();
        end
        chk("wrap_state_15", w_state, 0);
        chk("wrap_count_15", w_count, 15);
        cyc();
        cyc();
        cyc();
        instr_valid = 1'b0;
        chk("wrap_count_16", w_count, 0);
        chk("wide_count_16", instr_count, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
